// File: rtl/swc_pck_transfer_output.sv
`default_nettype none
// ============================================================================
//  Module      : swc_pck_transfer_output
//  Description : Per-port packet-transfer descriptor buffer. Descriptors from
//                the arbiter are queued in order and presented on the output
//                block's valid/ack interface. Optional drop counter is built
//                when SWC_PTO_DROP_CNT_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module swc_pck_transfer_output #(
    parameter int unsigned g_page_addr_width    = 10,
    parameter int unsigned g_prio_width         = 3,
    parameter int unsigned g_max_pck_size_width = 14,
    parameter int unsigned g_fifo_depth_log2    = 2
) (
    input  logic                            clk_i,
    input  logic                            rst_n_i,

    input  logic                            ib_transfer_pck_i,
    input  logic [g_page_addr_width-1:0]    ib_pageaddr_i,
    input  logic [g_prio_width-1:0]         ib_prio_i,
    input  logic [g_max_pck_size_width-1:0] ib_pck_size_i,
    output logic                            ib_ready_o,
    output logic                            ib_transfer_ack_o,

    output logic                            pta_transfer_data_valid_o,
    output logic [g_page_addr_width-1:0]    pta_pageaddr_o,
    output logic [g_prio_width-1:0]         pta_prio_o,
    output logic [g_max_pck_size_width-1:0] pta_pck_size_o,
    input  logic                            pta_transfer_data_ack_i,

    output logic [g_fifo_depth_log2:0]      level_o
`ifdef SWC_PTO_DROP_CNT_EN
    ,
    input  logic                            drop_clr_i,
    output logic [15:0]                     drop_cnt_o
`endif
);

    localparam int unsigned DEPTH = 1 << g_fifo_depth_log2;
    localparam int unsigned LW    = g_fifo_depth_log2 + 1;
    localparam int unsigned PW    = g_fifo_depth_log2;
    localparam int unsigned DW    = g_page_addr_width + g_prio_width + g_max_pck_size_width;

    localparam logic [LW-1:0] CAPACITY  = LW'(DEPTH);
    localparam logic [LW-1:0] LEVEL_ONE = LW'(1);
    localparam logic [PW-1:0] PTR_ONE   = PW'(1);

    logic [DW-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [LW-1:0] level;
    logic [DW-1:0] out_desc;
    logic          out_valid;
    logic          ack_pulse;

    logic [DW-1:0] in_desc;
    logic          ready;
    logic          accept;
    logic          pop;
    logic          out_free;
    logic          mem_empty;
    logic          load_head;
    logic          bypass;
    logic          mem_wr;

    assign in_desc = {ib_pageaddr_i, ib_prio_i, ib_pck_size_i};

    // Ready comes from the start-of-cycle level only, so a pop in the same
    // cycle never opens room for a strobe that arrived while full.
    assign ready  = (level < CAPACITY);
    assign accept = ib_transfer_pck_i & ready;
    assign pop    = out_valid & pta_transfer_data_ack_i;

    // The output register is only ever empty while the memory is empty, so
    // the memory holds at most DEPTH-1 entries and equal pointers mean empty.
    assign out_free  = ~out_valid | pop;
    assign mem_empty = (wr_ptr == rd_ptr);
    assign load_head = out_free & ~mem_empty;
    assign bypass    = out_free & mem_empty & accept;
    assign mem_wr    = accept & ~bypass;

    always_ff @(posedge clk_i) begin
        if (mem_wr) begin
            mem[wr_ptr] <= in_desc;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (mem_wr) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (load_head) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

    // Head of memory always wins over bypass to keep arrival order.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            out_desc  <= '0;
            out_valid <= 1'b0;
        end else if (load_head) begin
            out_desc  <= mem[rd_ptr];
            out_valid <= 1'b1;
        end else if (bypass) begin
            out_desc  <= in_desc;
            out_valid <= 1'b1;
        end else if (pop) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            level     <= '0;
            ack_pulse <= 1'b0;
        end else begin
            ack_pulse <= accept;
            unique case ({accept, pop})
                2'b10:   level <= level + LEVEL_ONE;
                2'b01:   level <= level - LEVEL_ONE;
                default: level <= level;
            endcase
        end
    end

`ifdef SWC_PTO_DROP_CNT_EN
    logic [15:0] drop_cnt;
    logic        drop;

    assign drop = ib_transfer_pck_i & ~ready;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            drop_cnt <= '0;
        end else if (drop_clr_i) begin
            drop_cnt <= '0;
        end else if (drop && (drop_cnt != 16'hFFFF)) begin
            drop_cnt <= drop_cnt + 16'd1;
        end
    end

    assign drop_cnt_o = drop_cnt;
`endif

    assign ib_ready_o                = ready;
    assign ib_transfer_ack_o         = ack_pulse;
    assign pta_transfer_data_valid_o = out_valid;
    assign pta_pageaddr_o            = out_desc[DW-1 -: g_page_addr_width];
    assign pta_prio_o                = out_desc[g_max_pck_size_width +: g_prio_width];
    assign pta_pck_size_o            = out_desc[g_max_pck_size_width-1:0];
    assign level_o                   = level;

endmodule

`default_nettype wire

// File: tb/tb_swc_pck_transfer_output.sv
`default_nettype none
// ============================================================================
//  Module      : tb_swc_pck_transfer_output
//  Description : Directed bench for swc_pck_transfer_output with a queue-based
//                reference model checked every cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_swc_pck_transfer_output;

    localparam int C = 4;

    typedef struct packed {
        logic [9:0]  page;
        logic [2:0]  prio;
        logic [13:0] size;
    } desc_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        strobe = 1'b0;
    logic [9:0]  ib_page = '0;
    logic [2:0]  ib_prio = '0;
    logic [13:0] ib_size = '0;
    logic        ready;
    logic        ib_ack;
    logic        valid;
    logic [9:0]  pta_page;
    logic [2:0]  pta_prio;
    logic [13:0] pta_size;
    logic        ack_in = 1'b0;
    logic [2:0]  level;
    logic        drop_clr = 1'b0;
    logic [15:0] drop_cnt;

    int checks = 0;
    int errors = 0;

    desc_t q[$];
    logic [9:0] popped[$];
    bit   exp_ack = 1'b0;
    int   exp_drop = 0;
    int   m_sz;
    bit   m_rdy;

    always #5 clk = ~clk;

    swc_pck_transfer_output dut (
        .clk_i                     (clk),
        .rst_n_i                   (rst_n),
        .ib_transfer_pck_i         (strobe),
        .ib_pageaddr_i             (ib_page),
        .ib_prio_i                 (ib_prio),
        .ib_pck_size_i             (ib_size),
        .ib_ready_o                (ready),
        .ib_transfer_ack_o         (ib_ack),
        .pta_transfer_data_valid_o (valid),
        .pta_pageaddr_o            (pta_page),
        .pta_prio_o                (pta_prio),
        .pta_pck_size_o            (pta_size),
        .pta_transfer_data_ack_i   (ack_in),
        .level_o                   (level)
`ifdef SWC_PTO_DROP_CNT_EN
        ,
        .drop_clr_i                (drop_clr),
        .drop_cnt_o                (drop_cnt)
`endif
    );

`ifndef SWC_PTO_DROP_CNT_EN
    assign drop_cnt = '0;
`endif

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference: a plain queue of descriptors; the head is what is presented.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            exp_ack  = 1'b0;
            exp_drop = 0;
        end else begin
            m_sz  = q.size();
            m_rdy = (m_sz < C);
            exp_ack = strobe && m_rdy;
            if (drop_clr)
                exp_drop = 0;
            else if (strobe && !m_rdy && exp_drop < 65535)
                exp_drop = exp_drop + 1;
            if (m_sz > 0 && ack_in)
                void'(q.pop_front());
            if (exp_ack)
                q.push_back('{page: ib_page, prio: ib_prio, size: ib_size});
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("m_ready", 32'(ready), 32'(q.size() < C));
            chk("m_level", 32'(level), 32'(q.size()));
            chk("m_ack",   32'(ib_ack), 32'(exp_ack));
            chk("m_valid", 32'(valid), 32'(q.size() > 0));
            if (q.size() > 0) begin
                chk("m_page", 32'(pta_page), 32'(q[0].page));
                chk("m_prio", 32'(pta_prio), 32'(q[0].prio));
                chk("m_size", 32'(pta_size), 32'(q[0].size));
            end
`ifdef SWC_PTO_DROP_CNT_EN
            chk("m_drop", 32'(drop_cnt), 32'(exp_drop));
`endif
        end
    end

    task automatic step(input bit s, input int page, input int prio, input int size, input bit a);
        strobe  = s;
        ib_page = 10'(page);
        ib_prio = 3'(prio);
        ib_size = 14'(size);
        ack_in  = a;
        if (valid && a)
            popped.push_back(pta_page);
        @(negedge clk);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (valid && n < 10) begin
            step(0, 0, 0, 0, 1);
            n++;
        end
        chk("drain_bound", 32'(valid), 32'd0);
        step(0, 0, 0, 0, 0);
    endtask

    initial begin
        #1_500_000;
        errors++;
        $display("FAIL watchdog: got timeout expected finish");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_ack",   32'(ib_ack), 32'd0);
        chk("rst_page",  32'(pta_page), 32'd0);
        chk("rst_size",  32'(pta_size), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // single descriptor, ack held
        popped.delete();
        step(1, 5, 7, 10, 1);
        chk("single_valid", 32'(valid), 32'd1);
        chk("single_page",  32'(pta_page), 32'd5);
        chk("single_prio",  32'(pta_prio), 32'd7);
        chk("single_size",  32'(pta_size), 32'd10);
        chk("single_ack",   32'(ib_ack), 32'd1);
        chk("single_lvl1",  32'(level), 32'd1);
        step(0, 0, 0, 0, 1);
        chk("single_lvl0",  32'(level), 32'd0);
        chk("single_vld0",  32'(valid), 32'd0);
        chk("single_npop",  32'(popped.size()), 32'd1);
        step(0, 0, 0, 0, 0);

        // fill past capacity, then back-to-back drain
        popped.delete();
        for (int i = 0; i < 6; i++) begin
            step(1, i, i, i + 100, 0);
            chk("fill_ack", 32'(ib_ack), 32'(i < 4));
        end
        chk("fill_level", 32'(level), 32'd4);
        chk("fill_ready", 32'(ready), 32'd0);
        for (int i = 0; i < 4; i++) begin
            chk("b2b_valid", 32'(valid), 32'd1);
            step(0, 0, 0, 0, 1);
        end
        chk("b2b_after", 32'(valid), 32'd0);
        chk("b2b_npop", 32'(popped.size()), 32'd4);
        for (int i = 0; i < 4 && i < popped.size(); i++)
            chk("b2b_order", 32'(popped[i]), 32'(i));
        step(0, 0, 0, 0, 0);

        // interleaved strobes with toggling ack
        popped.delete();
        for (int i = 0; i < 6; i++)
            step(1, 20 + i, i, i * 3, (i % 2) == 0);
        chk("mix_level", 32'(level), 32'd4);
        drain();
        chk("mix_npop", 32'(popped.size()), 32'd6);
        for (int i = 0; i < 6 && i < popped.size(); i++)
            chk("mix_order", 32'(popped[i]), 32'(20 + i));

        // strobe while full with a simultaneous pop is dropped
        drop_clr = 1'b1;
        step(0, 0, 0, 0, 0);
        drop_clr = 1'b0;
        for (int i = 0; i < 4; i++)
            step(1, 40 + i, 0, 1, 0);
        chk("full_level", 32'(level), 32'd4);
        step(1, 99, 1, 1, 1);
        chk("full_ack", 32'(ib_ack), 32'd0);
        chk("full_level3", 32'(level), 32'd3);
        chk("full_head", 32'(pta_page), 32'd41);
`ifdef SWC_PTO_DROP_CNT_EN
        chk("drop_one", 32'(drop_cnt), 32'd1);
        drop_clr = 1'b1;
        step(0, 0, 0, 0, 0);
        drop_clr = 1'b0;
        chk("drop_clr", 32'(drop_cnt), 32'd0);
`endif
        drain();

        // reset in the middle of a burst, with a coincident strobe
        for (int i = 0; i < 3; i++)
            step(1, 60 + i, 0, 2, 0);
        strobe  = 1'b1;
        ib_page = 10'd77;
        rst_n   = 1'b0;
        #1;
        chk("mrst_valid", 32'(valid), 32'd0);
        chk("mrst_level", 32'(level), 32'd0);
        chk("mrst_ready", 32'(ready), 32'd1);
        chk("mrst_page",  32'(pta_page), 32'd0);
        @(negedge clk);
        chk("mrst_ack", 32'(ib_ack), 32'd0);
        rst_n = 1'b1;
        step(1, 9, 2, 3, 0);
        chk("post_valid", 32'(valid), 32'd1);
        chk("post_page",  32'(pta_page), 32'd9);
        chk("post_ack",   32'(ib_ack), 32'd1);
        chk("post_level", 32'(level), 32'd1);
        drain();

`ifdef SWC_PTO_DROP_CNT_EN
        // saturation of the drop counter
        for (int i = 0; i < 4; i++)
            step(1, i, 0, 0, 0);
        for (int i = 0; i < 70000; i++)
            step(1, 500, 0, 0, 0);
        chk("drop_sat", 32'(drop_cnt), 32'h0000FFFF);
        drop_clr = 1'b1;
        step(0, 0, 0, 0, 0);
        drop_clr = 1'b0;
        chk("drop_sat_clr", 32'(drop_cnt), 32'd0);
        drain();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
